// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU/DIV/DIVU take DATA_W+2 cycles through CALC/FIX/DONE; MTHI/MTLO write in one cycle.
module mips_cpu_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nx;
    logic [CW-1:0] count;

    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   opnd;
    logic [DATA_W-1:0]   raw_a;
    logic                is_div;
    logic                neg_main;
    logic                neg_rem;
    logic                div_zero;

    logic accept, is_arith, is_mt, signed_op;

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic sgn);
        logic signed [DATA_W-1:0] s;
        s = signed'(v);
        return (sgn && s < 0) ? unsigned'(-s) : v;
    endfunction

    function automatic logic [DATA_W-1:0] negate_if(input logic [DATA_W-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    always_comb begin
        accept    = start && (state == IDLE || state == DONE);
        is_arith  = (op >= OP_MULT) && (op <= OP_DIVU);
        is_mt     = (op == OP_MTHI) || (op == OP_MTLO);
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        state_nx  = state;
        case (state)
            IDLE, DONE: begin
                if (state == DONE)
                    state_nx = IDLE;
                if (accept && is_arith)
                    state_nx = CALC;
                else if (accept && is_mt)
                    state_nx = IDLE;
            end
            CALC:    if (count == LAST) state_nx = FIX;
            FIX:     state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        busy = (state == CALC) || (state == FIX);
        done = (state == DONE);
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     partial;
    logic [DATA_W:0]     diff;
    logic                ge;
    logic [DATA_W-1:0]   new_rem;
    logic [2*DATA_W-1:0] acc_nx;

    always_comb begin
        mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
        partial = acc[2*DATA_W-1:DATA_W-1];
        diff    = partial - {1'b0, opnd};
        ge      = partial >= {1'b0, opnd};
        new_rem = ge ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
        if (is_div)
            acc_nx = {new_rem, acc[DATA_W-2:0], ge};
        else
            acc_nx = {mul_sum, acc[DATA_W-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nx;
            if (accept && is_arith)
                count <= '0;
            else if (state == CALC)
                count <= count + CW'(1);
            if (accept && op == OP_MTHI)
                hi <= a;
            if (accept && op == OP_MTLO)
                lo <= a;
            if (state == FIX) begin
                if (!is_div) begin
                    {hi, lo} <= neg_main ? -acc : acc;
                end else if (div_zero) begin
                    lo <= '1;
                    hi <= raw_a;
                end else begin
                    lo <= negate_if(acc[DATA_W-1:0], neg_main);
                    hi <= negate_if(acc[2*DATA_W-1:DATA_W], neg_rem);
                end
            end
        end
    end

    // Datapath operands and accumulator carry no reset; they are reloaded on every accept.
    always_ff @(posedge clk) begin
        if (accept && is_arith) begin
            is_div   <= (op == OP_DIV) || (op == OP_DIVU);
            neg_main <= signed_op && (a[DATA_W-1] ^ b[DATA_W-1]);
            neg_rem  <= signed_op && a[DATA_W-1];
            div_zero <= (b == '0);
            raw_a    <= a;
            if ((op == OP_DIV) || (op == OP_DIVU)) begin
                acc  <= {{DATA_W{1'b0}}, magnitude(a, signed_op)};
                opnd <= magnitude(b, signed_op);
            end else begin
                acc  <= {{DATA_W{1'b0}}, magnitude(b, signed_op)};
                opnd <= magnitude(a, signed_op);
            end
        end else if (state == CALC) begin
            acc <= acc_nx;
        end
    end
endmodule
